// File: rtl/maze_dfs_controller.sv
// maze_dfs_controller
//   Depth-first search over a 16x16 maze held in an external 1-bit-per-cell map.
//   The path is kept in an external 2-bit direction stack. When the search
//   reaches the target, the stack holds the route from (0,0). The first move is
//   at the bottom of the stack.
//
// Parameters
//   TARGET_ROW, TARGET_COL : target cell, each 0..15
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   start             : begin a search; sampled only in IDLE, DONE or FAIL
//   map_addr          : {row,col} of the cell under examination
//   map_data          : 1 = wall; combinational response to map_addr
//   stk_push, stk_pop : stack control
//   stk_data_in       : direction to push
//   stk_data_out      : popped direction, valid the cycle after stk_pop
//   stk_empty/full    : stack status
//   cur_row, cur_col  : current position
//   busy, done, fail  : run status; done/fail held until the next accepted start
module maze_dfs_controller #(
  parameter int unsigned TARGET_ROW = 15,
  parameter int unsigned TARGET_COL = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] map_addr,
  input  logic       map_data,
  output logic       stk_push,
  output logic       stk_pop,
  output logic [1:0] stk_data_in,
  input  logic [1:0] stk_data_out,
  input  logic       stk_empty,
  input  logic       stk_full,
  output logic [3:0] cur_row,
  output logic [3:0] cur_col,
  output logic       busy,
  output logic       done,
  output logic       fail
);

  localparam logic [3:0] TgtRow = TARGET_ROW[3:0];
  localparam logic [3:0] TgtCol = TARGET_COL[3:0];

  typedef enum logic [2:0] {StIdle, StCheck, StMove, StPop, StBack, StDone, StFail} state_e;

  state_e       state_q, state_d;
  logic [3:0]   row_q, row_d, col_q, col_d;
  logic [2:0]   d_q, d_d;            // try counter; 4 means all directions exhausted
  logic [255:0] visited_q, visited_d;

  logic [3:0] cand_row, cand_col;
  logic [7:0] cand_addr;
  logic       cand_inb, cand_valid, at_target, can_start;

  // Neighbour in direction d_q[1:0]. In-bounds test prevents wrap-around.
  always_comb begin
    cand_row = row_q;
    cand_col = col_q;
    cand_inb = 1'b0;
    unique case (d_q[1:0])
      2'd0: begin cand_row = row_q - 4'd1; cand_inb = (row_q != 4'd0);  end
      2'd1: begin cand_col = col_q + 4'd1; cand_inb = (col_q != 4'd15); end
      2'd2: begin cand_row = row_q + 4'd1; cand_inb = (row_q != 4'd15); end
      2'd3: begin cand_col = col_q - 4'd1; cand_inb = (col_q != 4'd0);  end
    endcase
  end

  assign cand_addr  = {cand_row, cand_col};
  // map_data reflects cand_addr only in CHECK, which is the only place this is used.
  assign cand_valid = cand_inb & ~map_data & ~visited_q[cand_addr];
  assign at_target  = (row_q == TgtRow) && (col_q == TgtCol);
  assign can_start  = (state_q == StIdle) || (state_q == StDone) || (state_q == StFail);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      row_q     <= 4'd0;
      col_q     <= 4'd0;
      d_q       <= 3'd0;
      visited_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      d_q       <= d_d;
      visited_q <= visited_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    d_d       = d_q;
    visited_d = visited_q;
    unique case (state_q)
      StIdle, StDone, StFail: begin
        if (start) begin
          row_d     = 4'd0;
          col_d     = 4'd0;
          d_d       = 3'd0;
          visited_d = '0;
          if (map_data) begin
            state_d = StFail;
          end else begin
            visited_d[0] = 1'b1;
            state_d      = StCheck;
          end
        end
      end
      StCheck: begin
        if (at_target) begin
          state_d = StDone;
        end else if (d_q == 3'd4) begin
          state_d = stk_empty ? StFail : StPop;
        end else if (cand_valid) begin
          state_d = stk_full ? StFail : StMove;
        end else begin
          d_d = d_q + 3'd1;
        end
      end
      StMove: begin
        // d_q still holds the chosen direction, so cand_* is the cell to enter.
        row_d                = cand_row;
        col_d                = cand_col;
        visited_d[cand_addr] = 1'b1;
        d_d                  = 3'd0;
        state_d              = StCheck;
      end
      StPop: begin
        state_d = StBack;
      end
      StBack: begin
        // Undo the popped move, then resume with the next untried direction.
        unique case (stk_data_out)
          2'd0: row_d = row_q + 4'd1;
          2'd1: col_d = col_q - 4'd1;
          2'd2: row_d = row_q - 4'd1;
          2'd3: col_d = col_q + 4'd1;
        endcase
        d_d     = {1'b0, stk_data_out} + 3'd1;
        state_d = StCheck;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    map_addr    = {row_q, col_q};
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_data_in = 2'd0;
    if (state_q == StCheck) begin
      map_addr = cand_addr;
    end else if (can_start && start) begin
      // The start check probes (0,0) even if the previous run ended elsewhere.
      map_addr = 8'd0;
    end
    if (state_q == StMove) begin
      stk_push    = 1'b1;
      stk_data_in = d_q[1:0];
    end
    if (state_q == StPop) begin
      stk_pop = 1'b1;
    end
  end

  assign cur_row = row_q;
  assign cur_col = col_q;
  assign busy    = (state_q == StCheck) || (state_q == StMove) ||
                   (state_q == StPop)   || (state_q == StBack);
  assign done    = (state_q == StDone);
  assign fail    = (state_q == StFail);

endmodule

// File: tb/tb_maze_dfs_controller.sv
module tb_maze_dfs_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] map_addr;
  logic       map_data;
  logic       stk_push, stk_pop;
  logic [1:0] stk_data_in, stk_data_out;
  logic       stk_empty, stk_full;
  logic [3:0] cur_row, cur_col;
  logic       busy, done, fail;

  always #5 clk = ~clk;

  // Target (2,0) lets small hand-built mazes exercise forward moves and backtracking.
  maze_dfs_controller #(.TARGET_ROW(2), .TARGET_COL(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .map_addr     (map_addr),
    .map_data     (map_data),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .stk_empty    (stk_empty),
    .stk_full     (stk_full),
    .cur_row      (cur_row),
    .cur_col      (cur_col),
    .busy         (busy),
    .done         (done),
    .fail         (fail)
  );

  // Maze map: index = row*16 + col
  logic wall [256];
  assign map_data = wall[map_addr];

  // Direction stack model, depth 256, registered pop data
  logic [1:0] stk_mem [256];
  int         sp = 0;
  logic [1:0] stk_q = 2'd0;
  assign stk_empty    = (sp == 0);
  assign stk_full     = (sp == 256);
  assign stk_data_out = stk_q;

  always @(posedge clk) begin
    if (rst) begin
      sp    <= 0;
      stk_q <= 2'd0;
    end else if (stk_push && sp < 256) begin
      stk_mem[sp] <= stk_data_in;
      sp          <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_q <= stk_mem[sp-1];
      sp    <= sp - 1;
    end
  end

  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(string name, int act, int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Scoreboard: kind 0 = push, 1 = pop, 2 = done rise, 3 = fail rise
  typedef struct {
    int kind;
    int data;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  function automatic void expect_ev(int k, int dta, int c);
    ev_t e;
    e.kind = k;
    e.data = dta;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  function automatic void observe(int k, int dta);
    ev_t e;
    int  rel;
    rel = cyc - base + 1;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected event: got kind %0d data %0d at cycle %0d, expected none",
               k, dta, rel);
    end else begin
      e = exp_q.pop_front();
      check("event kind", k, e.kind);
      check("event data", dta, e.data);
      check("event cycle", rel, e.cyc);
    end
  endfunction

  // Monitor
  logic done_prev = 1'b0;
  logic fail_prev = 1'b0;
  always @(negedge clk) begin
    if (stk_push) observe(0, int'(stk_data_in));
    if (stk_pop) observe(1, 0);
    if (stk_push && stk_pop) check("push and pop together", 1, 0);
    if (done && !done_prev) observe(2, 0);
    if (fail && !fail_prev) observe(3, 0);
    done_prev = done;
    fail_prev = fail;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_walls(input int a, input int b);
    for (int i = 0; i < 256; i++) wall[i] = 1'b0;
    if (a >= 0) wall[a] = 1'b1;
    if (b >= 0) wall[b] = 1'b1;
  endtask

  // Returns inside cycle 1 (just after the accepting edge E0).
  task automatic start_search();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    base  = cyc;
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 80;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (4) @(negedge clk);
    check({name, " pending events"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_stack(input string name, input int n);
    check({name, " stack depth"}, sp, n);
    for (int i = 0; i < n; i++) check({name, " stack entry"}, int'(stk_mem[i]), 2);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " done"}, int'(done), 0);
    check({name, " fail"}, int'(fail), 0);
    check({name, " busy"}, int'(busy), 0);
    check({name, " stk_push"}, int'(stk_push), 0);
    check({name, " stk_pop"}, int'(stk_pop), 0);
    check({name, " stk_data_in"}, int'(stk_data_in), 0);
    check({name, " map_addr"}, int'(map_addr), 0);
    check({name, " cur_row"}, int'(cur_row), 0);
    check({name, " cur_col"}, int'(cur_col), 0);
  endtask

  // Dead end at (0,1): walls (0,2),(1,1). Push 1, backtrack, then push 2 twice.
  task automatic expect_dead_end();
    expect_ev(0, 1, 3);
    expect_ev(1, 0, 9);
    expect_ev(0, 2, 12);
    expect_ev(0, 2, 16);
    expect_ev(2, 0, 18);
  endtask

  // Straight down: walls (0,1),(1,1).
  task automatic expect_straight();
    expect_ev(0, 2, 4);
    expect_ev(0, 2, 8);
    expect_ev(2, 0, 10);
  endtask

  initial begin
    set_walls(-1, -1);
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Straight path, with a start pulse while busy that must be ignored
    set_walls(1, 17);
    expect_straight();
    start_search();
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("straight");
    check_stack("straight", 2);
    check("straight done level", int'(done), 1);

    // Start again from DONE without reset: done clears, same path is found again
    expect_straight();
    start_search();
    check("restart done cleared", int'(done), 0);
    check("restart busy", int'(busy), 1);
    drain("restart");
    check_stack("restart", 4);

    // Dead end with one backtrack
    do_reset();
    set_walls(2, 17);
    expect_dead_end();
    start_search();
    drain("dead end");
    check_stack("dead end", 2);

    // Enclosed start: all four directions rejected, then d==4 with empty stack
    do_reset();
    set_walls(1, 16);
    expect_ev(3, 0, 6);
    start_search();
    drain("enclosed");
    check("enclosed stack depth", sp, 0);
    check("enclosed done", int'(done), 0);

    // Wall on the start cell
    do_reset();
    set_walls(0, -1);
    expect_ev(3, 0, 1);
    start_search();
    for (int i = 0; i < 4; i++) begin
      check("start wall busy", int'(busy), 0);
      @(negedge clk);
    end
    drain("start wall");
    check("start wall stack depth", sp, 0);

    // Reset during cycle 10 of the dead-end search (the BACK cycle)
    do_reset();
    set_walls(2, 17);
    expect_ev(0, 1, 3);
    expect_ev(1, 0, 9);
    start_search();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid reset");
    check("mid reset pending events", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    expect_dead_end();
    start_search();
    drain("after reset");
    check_stack("after reset", 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
